// File: rtl/mem_stage_lsu_if.sv
// Data-bus request/response channel between the memory-stage LSU and the data memory.
// Zero latency: plain wires with no storage.
// The request half is valid/ready; the response half is valid-only and cannot be stalled.
interface mem_stage_lsu_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    dbus_req_valid;
  logic                    dbus_req_ready;
  logic                    dbus_req_write;
  logic [ADDR_WIDTH-1:0]   dbus_req_addr;
  logic [DATA_WIDTH-1:0]   dbus_req_wdata;
  logic [DATA_WIDTH/8-1:0] dbus_req_wstrb;
  logic                    dbus_resp_valid;
  logic [DATA_WIDTH-1:0]   dbus_resp_rdata;

  // LSU side: it issues requests and consumes responses.
  modport master (
    output dbus_req_valid, dbus_req_write, dbus_req_addr, dbus_req_wdata, dbus_req_wstrb,
    input  dbus_req_ready, dbus_resp_valid, dbus_resp_rdata
  );

  // Memory side: it accepts requests and returns responses.
  modport slave (
    input  dbus_req_valid, dbus_req_write, dbus_req_addr, dbus_req_wdata, dbus_req_wstrb,
    output dbus_req_ready, dbus_resp_valid, dbus_resp_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one outstanding dbus transaction, lane steering, and load extension.
// Latency: minimum 3 stall cycles, with lsu_done in the 4th; forced completion after TIMEOUT_CYCLES in REQ+WAIT.
// Backpressure: holds dbus_req_valid until dbus_req_ready, and stalls the upstream register until DONE.
// Optional: `define LSU_MISALIGN_CHECK_EN to trap misaligned accesses instead of aligning them down.
module mem_stage_lsu #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  is_unsigned,
  input  logic [3:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_address,
  input  logic [DATA_WIDTH-1:0] store_data,
  mem_stage_lsu_if.master       dbus,
  output logic                  lsu_stall,
  output logic                  lsu_done,
  output logic [DATA_WIDTH-1:0] opload_read_data_wb,
  output logic                  bus_timeout,
  output logic                  misalign_exc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // A 10-bit counter covers the full 2..1023 timeout range.
  localparam int              CNT_W    = 10;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;

  // Operation attributes, latched when the op leaves IDLE.
  logic       op_store;
  logic       op_unsigned;
  logic [1:0] op_sz_log2;
  logic [2:0] op_off;

  logic       mem_op;
  logic       tmo_hit;
  logic [1:0] sz_log2;
  logic [7:0] strb_base;
  logic [2:0] raw_off;
  logic [2:0] lane_off;
  logic [7:0] wstrb_nxt;
  logic [63:0] wdata_nxt;
  logic [63:0] load_shifted;
  logic [63:0] load_ext;

  assign mem_op  = instr_valid & (is_load | is_store);
  assign raw_off = ls_address[2:0];
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Decode the one-hot size; any illegal code is handled as a doubleword.
  always_comb begin
    sz_log2   = 2'd3;
    strb_base = 8'hFF;
    case (ls_size)
      4'b0001: begin sz_log2 = 2'd0; strb_base = 8'h01; end
      4'b0010: begin sz_log2 = 2'd1; strb_base = 8'h03; end
      4'b0100: begin sz_log2 = 2'd2; strb_base = 8'h0F; end
      default: begin sz_log2 = 2'd3; strb_base = 8'hFF; end
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic misaligned;

  // Misaligned accesses are trapped, so the raw offset is used directly for lanes.
  always_comb begin
    lane_off = raw_off;
    case (sz_log2)
      2'd1:    misaligned = raw_off[0];
      2'd2:    misaligned = |raw_off[1:0];
      2'd3:    misaligned = |raw_off;
      default: misaligned = 1'b0;
    endcase
  end
`else
  // Without trapping, clear the offset bits below the access size so the access never crosses 8 bytes.
  always_comb begin
    case (sz_log2)
      2'd0:    lane_off = raw_off;
      2'd1:    lane_off = {raw_off[2:1], 1'b0};
      2'd2:    lane_off = {raw_off[2], 2'b00};
      default: lane_off = 3'b000;
    endcase
  end

  assign misalign_exc = 1'b0;
`endif

  assign wstrb_nxt    = strb_base << lane_off;
  assign wdata_nxt    = store_data << {lane_off, 3'b000};
  assign load_shifted = dbus.dbus_resp_rdata >> {op_off, 3'b000};

  // Select the addressed bytes of the response and extend them to 64 bits.
  always_comb begin
    load_ext = load_shifted;
    case (op_sz_log2)
      2'd0:    load_ext = {{56{~op_unsigned & load_shifted[7]}},  load_shifted[7:0]};
      2'd1:    load_ext = {{48{~op_unsigned & load_shifted[15]}}, load_shifted[15:0]};
      2'd2:    load_ext = {{32{~op_unsigned & load_shifted[31]}}, load_shifted[31:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // The stall is combinational, so the pipeline register is held in the same cycle the op appears.
  assign lsu_stall = ((state == IDLE) & mem_op) | (state == REQ) | (state == WAIT);

  // Transaction FSM, with registered bus request, completion pulses and load result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      tmo_cnt             <= '0;
      op_store            <= 1'b0;
      op_unsigned         <= 1'b0;
      op_sz_log2          <= 2'd0;
      op_off              <= 3'd0;
      dbus.dbus_req_valid <= 1'b0;
      dbus.dbus_req_write <= 1'b0;
      dbus.dbus_req_addr  <= '0;
      dbus.dbus_req_wdata <= '0;
      dbus.dbus_req_wstrb <= '0;
      lsu_done            <= 1'b0;
      opload_read_data_wb <= '0;
      bus_timeout         <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_exc        <= 1'b0;
`endif
    end else begin
      lsu_done    <= 1'b0;
      bus_timeout <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_exc <= 1'b0;
`endif
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (mem_op) begin
            op_store    <= is_store;
            op_unsigned <= is_unsigned;
            op_sz_log2  <= sz_log2;
            op_off      <= lane_off;
`ifdef LSU_MISALIGN_CHECK_EN
            if (misaligned) begin
              state               <= DONE;
              lsu_done            <= 1'b1;
              misalign_exc        <= 1'b1;
              opload_read_data_wb <= '0;
            end else
`endif
            begin
              state               <= REQ;
              dbus.dbus_req_valid <= 1'b1;
              dbus.dbus_req_write <= is_store;
              dbus.dbus_req_addr  <= {ls_address[ADDR_WIDTH-1:3], 3'b000};
              dbus.dbus_req_wdata <= wdata_nxt;
              dbus.dbus_req_wstrb <= is_store ? wstrb_nxt : 8'h00;
            end
          end
        end
        REQ: begin
          if (tmo_hit) begin
            state               <= DONE;
            dbus.dbus_req_valid <= 1'b0;
            opload_read_data_wb <= '0;
            bus_timeout         <= 1'b1;
            lsu_done            <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (dbus.dbus_req_ready) begin
              state               <= WAIT;
              dbus.dbus_req_valid <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (tmo_hit) begin
            state               <= DONE;
            opload_read_data_wb <= '0;
            bus_timeout         <= 1'b1;
            lsu_done            <= 1'b1;
          end else if (dbus.dbus_resp_valid) begin
            state               <= DONE;
            lsu_done            <= 1'b1;
            opload_read_data_wb <= op_store ? 64'd0 : load_ext;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit, directly downstream of the execute→memory pipeline register.
- Takes the registered load/store control and the computed ls_address, runs a single-outstanding request/response transaction on the data bus, and produces the aligned, extended load result for the memory→writeback pipeline register (opload_read_data_wb).
- Drives lsu_stall into the pipeline-register stall network while a transaction is in flight.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, bus data width; fixed at 64 (8 byte lanes).
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ plus WAIT before forced completion; legal range 2..1023.

Ports:
- clock  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  memory-stage instruction valid.
- is_load  in  1  instruction is a load.
- is_store  in  1  instruction is a store.
- is_unsigned  in  1  zero-extend load result; sign-extend when 0.
- ls_size  in  4  one-hot size: 0001 byte, 0010 half, 0100 word, 1000 double.
- ls_address  in  ADDR_WIDTH  effective address.
- store_data  in  64  store source, right-aligned.
- dbus_req_valid  out  1  request valid.
- dbus_req_ready  in  1  request accepted when valid & ready.
- dbus_req_write  out  1  1 = store.
- dbus_req_addr  out  ADDR_WIDTH  8-byte-aligned address.
- dbus_req_wdata  out  64  lane-positioned store data.
- dbus_req_wstrb  out  8  byte write strobes; 0 for loads.
- dbus_resp_valid  in  1  response/ack valid.
- dbus_resp_rdata  in  64  response data.
- lsu_stall  out  1  combinational; holds the upstream pipeline register.
- lsu_done  out  1  one-cycle pulse on completion.
- opload_read_data_wb  out  64  extended load result.
- bus_timeout  out  1  one-cycle pulse on forced completion.
- misalign_exc  out  1  one-cycle misalignment pulse (optional feature).

Behaviour:
- mem_op = instr_valid & (is_load | is_store).
- Upstream holds all inputs stable while lsu_stall=1.
- Reset values: state IDLE; dbus_req_valid, dbus_req_write, dbus_req_addr, dbus_req_wdata, dbus_req_wstrb, lsu_done, opload_read_data_wb, bus_timeout, misalign_exc all 0; timeout counter 0.
- Reset asserted mid-transaction aborts it. Any later bus response is ignored because the FSM is in IDLE.
- FSM: IDLE, REQ, WAIT, DONE.
  - IDLE: if mem_op → REQ. Register dbus_req_valid=1 and drive addr = {ls_address[63:3],3'b000}, write = is_store, wstrb, wdata.
  - REQ: dbus_req_valid held at 1 and all request fields held stable until dbus_req_ready. On the accepting edge → WAIT and clear dbus_req_valid.
  - WAIT: on dbus_resp_valid → DONE. Capture the load result, or 0 for stores.
  - dbus_resp_valid is ignored in IDLE, REQ and DONE.
  - DONE: lsu_done=1 for this cycle, then → IDLE unconditionally.
- lsu_stall = (IDLE & mem_op) | REQ | WAIT. It is 0 in DONE, so the pipeline advances at the end of DONE.
- A back-to-back op is first seen in the following IDLE cycle.
- Minimum latency with ready=1 and response one cycle after acceptance: stall for 3 cycles, DONE in the 4th.
- Store lanes, with off = ls_address[2:0]:
  - wstrb = (byte 0x01, half 0x03, word 0x0F, double 0xFF) << off, truncated to 8 bits.
  - wdata = store_data << (8*off).
- Load data:
  - sh = dbus_resp_rdata >> (8*off).
  - Take 8/16/32/64 bits by size.
  - Zero-extend if is_unsigned, else sign-extend to 64.
- Any ls_size other than the four legal one-hot codes is treated as double.
- opload_read_data_wb updates only in the WAIT→DONE transition, or on forced completion. It holds its value otherwise.
- Timeout counter:
  - Cleared in IDLE; increments each cycle in REQ and WAIT.
  - On reaching TIMEOUT_CYCLES → DONE with opload_read_data_wb=0, bus_timeout=1 and dbus_req_valid cleared.
  - Timeout takes priority over a same-cycle ready or response.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned access (half with off[0]≠0, word with off[1:0]≠0, double with off≠0) goes IDLE→DONE directly.
  - No bus request is issued; lsu_stall=1 for one cycle.
  - In DONE: misalign_exc=1, lsu_done=1, opload_read_data_wb=0.
- Not defined:
  - misalign_exc is tied 0.
  - The low address bits below the access size are cleared before lane computation (access is aligned down).

Test Plan:
- Unsigned byte load at 0x1003, ready=1, response rdata=0x8877665544332211 one cycle after acceptance → req_addr=0x1000, wstrb=0x00, lsu_stall high 3 cycles, opload_read_data_wb=0x0000000000000044, lsu_done pulse.
- Signed half load at 0x1006, same rdata → opload_read_data_wb=0xFFFFFFFFFFFF8877.
- Word store at 0x2004, store_data=0x00000000DEADBEEF → req_write=1, wstrb=0xF0, wdata=0xDEADBEEF00000000; completes on ack; opload_read_data_wb=0.
- dbus_req_ready low for 4 cycles → req_valid, addr, wdata and wstrb stable throughout, stall held, acceptance on the 5th cycle.
- TIMEOUT_CYCLES=16 with no response → bus_timeout pulse exactly 16 cycles after entering REQ, opload_read_data_wb=0, stall released.
- Word load at 0x1002: with the macro → misalign_exc pulse and no dbus_req_valid; without it → req_addr=0x1000, result taken from bytes 0–3.
